// File: rtl/fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_if
// Groups the fetch sequencer's control/status signals.
//   The slave modport is the sequencer.
//   The master modport is its environment: hazard unit, later stages and IF stage.
// Signals:
//   start         begin fetching from IDLE
//   hazardStall   stall request from the hazard unit
//   brReq         taken-branch redirect request from a later stage
//   brReqOffset   redirect offset accompanying brReq
//   instruction   instruction currently presented by the IF stage
//   brTaken       IF stage selects brOffset instead of +4
//   brOffset      offset to the IF stage PC adder
//   freeze        IF stage holds PC while 1
//   flush         squashes the IF/ID pipeline register
//   running       fetch active
//   halted        halt opcode reached
//   redirectCount number of redirects performed (wraps)
// ----------------------------------------------------------------------------
interface fetch_sequencer_if #(
    parameter int unsigned ADDR_W = 24
);
    logic              start;
    logic              hazardStall;
    logic              brReq;
    logic [ADDR_W-1:0] brReqOffset;
    logic [15:0]       instruction;
    logic              brTaken;
    logic [ADDR_W-1:0] brOffset;
    logic              freeze;
    logic              flush;
    logic              running;
    logic              halted;
    logic [15:0]       redirectCount;

    modport slave (
        input  start, hazardStall, brReq, brReqOffset, instruction,
        output brTaken, brOffset, freeze, flush, running, halted, redirectCount
    );

    modport master (
        output start, hazardStall, brReq, brReqOffset, instruction,
        input  brTaken, brOffset, freeze, flush, running, halted, redirectCount
    );
endinterface

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Controls the instruction-fetch stage. It handles:
//   - starting fetch;
//   - hazard stalls;
//   - taken-branch redirects, followed by a drain of wrong-path instructions;
//   - halting on a dedicated opcode.
// Ports:
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  fetch_sequencer_if.slave (see the interface for the signal list)
// Parameters:
//   ADDR_W        PC/offset width
//   FLUSH_CYCLES  unstalled drain cycles after a redirect (0..7)
//   HALT_OP       opcode in instruction[15:12] that halts fetch
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned ADDR_W       = 24,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [3:0]  HALT_OP      = 4'hF
) (
    input  logic                  clk,
    input  logic                  rst,
    fetch_sequencer_if.slave      bus
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RUN      = 3'd1;
    localparam logic [2:0] ST_REDIRECT = 3'd2;
    localparam logic [2:0] ST_DRAIN    = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    // Drain length is a 3-bit quantity; a zero length skips DRAIN entirely.
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
    localparam bit         HAS_DRAIN  = (FLUSH_LOAD != 3'd0);

    logic [2:0]        state_r;
    logic [2:0]        state_s;
    logic [ADDR_W-1:0] offset_r;
    logic [ADDR_W-1:0] offset_s;
    logic [2:0]        drain_cnt_r;
    logic [2:0]        drain_cnt_s;
    logic [15:0]       redirect_count_r;
    logic [15:0]       redirect_count_s;
    logic              halt_op_s;

    assign halt_op_s = (bus.instruction[15:12] == HALT_OP);

    // Next-state and next-datapath computation.
    always_comb begin
        state_s          = state_r;
        offset_s         = offset_r;
        drain_cnt_s      = drain_cnt_r;
        redirect_count_s = redirect_count_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // A redirect wins over both a stall and a halt opcode.
                if (bus.brReq) begin
                    offset_s         = bus.brReqOffset;
                    redirect_count_s = redirect_count_r + 16'd1;
                    state_s          = ST_REDIRECT;
                end else if (!bus.hazardStall && halt_op_s) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_REDIRECT: begin
                // Always one cycle: brTaken overrides any stall.
                drain_cnt_s = FLUSH_LOAD;
                if (HAS_DRAIN) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                // Only unstalled cycles consume drain slots. Wrong-path
                // brReq and halt opcodes are ignored here.
                if (bus.hazardStall) begin
                    state_s = ST_DRAIN;
                end else if (drain_cnt_r <= 3'd1) begin
                    drain_cnt_s = 3'd0;
                    state_s     = ST_RUN;
                end else begin
                    drain_cnt_s = drain_cnt_r - 3'd1;
                    state_s     = ST_DRAIN;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r          <= ST_IDLE;
            offset_r         <= '0;
            drain_cnt_r      <= 3'd0;
            redirect_count_r <= 16'd0;
        end else begin
            state_r          <= state_s;
            offset_r         <= offset_s;
            drain_cnt_r      <= drain_cnt_s;
            redirect_count_r <= redirect_count_s;
        end
    end

    // Output decode from the registered state. Freeze follows the stall
    // input combinationally while fetch is live.
    always_comb begin
        bus.freeze   = 1'b1;
        bus.brTaken  = 1'b0;
        bus.brOffset = '0;
        bus.flush    = 1'b0;
        bus.running  = 1'b0;
        bus.halted   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bus.freeze = 1'b1;
            end
            ST_RUN: begin
                bus.freeze  = bus.hazardStall;
                bus.running = 1'b1;
            end
            ST_REDIRECT: begin
                bus.freeze   = 1'b0;
                bus.brTaken  = 1'b1;
                bus.brOffset = offset_r;
                bus.flush    = 1'b1;
                bus.running  = 1'b1;
            end
            ST_DRAIN: begin
                bus.freeze  = bus.hazardStall;
                bus.flush   = 1'b1;
                bus.running = 1'b1;
            end
            ST_HALT: begin
                bus.freeze = 1'b1;
                bus.halted = 1'b1;
            end
            default: begin
                bus.freeze = 1'b1;
            end
        endcase
    end

    assign bus.redirectCount = redirect_count_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed testbench. It drives two fetch sequencers:
//   dut_a  default build (two drain cycles);
//   dut_z  FLUSH_CYCLES = 0 build.
// Outputs are compared against hand-computed values.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic clk;
    logic rst;
    int   vec_cnt;
    int   err_cnt;

    fetch_sequencer_if #(.ADDR_W(24)) bus_a ();
    fetch_sequencer_if #(.ADDR_W(24)) bus_z ();

    fetch_sequencer #(.ADDR_W(24), .FLUSH_CYCLES(2), .HALT_OP(4'hF)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    fetch_sequencer #(.ADDR_W(24), .FLUSH_CYCLES(0), .HALT_OP(4'hF)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt = vec_cnt + 1;
        if (obs !== exp) begin
            err_cnt = err_cnt + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_a(input string tag);
        check_val({tag, ".freeze"},  32'(bus_a.freeze),        32'd1);
        check_val({tag, ".brTaken"}, 32'(bus_a.brTaken),       32'd0);
        check_val({tag, ".brOffset"},32'(bus_a.brOffset),      32'd0);
        check_val({tag, ".flush"},   32'(bus_a.flush),         32'd0);
        check_val({tag, ".running"}, 32'(bus_a.running),       32'd0);
        check_val({tag, ".halted"},  32'(bus_a.halted),        32'd0);
        check_val({tag, ".count"},   32'(bus_a.redirectCount), 32'd0);
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        bus_a.start = 1'b0; bus_a.hazardStall = 1'b0; bus_a.brReq = 1'b0;
        bus_a.brReqOffset = 24'h0; bus_a.instruction = 16'h0000;
        bus_z.start = 1'b0; bus_z.hazardStall = 1'b0; bus_z.brReq = 1'b0;
        bus_z.brReqOffset = 24'h0; bus_z.instruction = 16'h0000;

        // Reset values.
        tick();
        tick();
        check_reset_a("rst");

        // IDLE holds without start.
        rst = 1'b0;
        tick();
        check_val("idle_hold.running", 32'(bus_a.running), 32'd0);

        // Start, then freeze follows a 3-cycle stall.
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        #1;
        check_val("start.running", 32'(bus_a.running), 32'd1);
        check_val("start.freeze",  32'(bus_a.freeze),  32'd0);
        bus_a.hazardStall = 1'b1;
        #1;
        check_val("stall1.freeze", 32'(bus_a.freeze), 32'd1);
        tick();
        check_val("stall2.freeze", 32'(bus_a.freeze), 32'd1);
        tick();
        check_val("stall3.freeze", 32'(bus_a.freeze), 32'd1);
        tick();
        bus_a.hazardStall = 1'b0;
        #1;
        check_val("unstall.freeze",  32'(bus_a.freeze),  32'd0);
        check_val("unstall.running", 32'(bus_a.running), 32'd1);

        // Plain redirect with offset 0x10, then two drain cycles.
        bus_a.brReq = 1'b1;
        bus_a.brReqOffset = 24'h000010;
        tick();
        bus_a.brReq = 1'b0;
        bus_a.brReqOffset = 24'h0;
        #1;
        check_val("redir.brTaken",  32'(bus_a.brTaken),       32'd1);
        check_val("redir.brOffset", 32'(bus_a.brOffset),      32'h10);
        check_val("redir.flush",    32'(bus_a.flush),         32'd1);
        check_val("redir.freeze",   32'(bus_a.freeze),        32'd0);
        check_val("redir.count",    32'(bus_a.redirectCount), 32'd1);
        tick();
        check_val("drain1.flush",    32'(bus_a.flush),    32'd1);
        check_val("drain1.brTaken",  32'(bus_a.brTaken),  32'd0);
        check_val("drain1.brOffset", 32'(bus_a.brOffset), 32'd0);
        tick();
        check_val("drain2.flush", 32'(bus_a.flush), 32'd1);
        tick();
        check_val("run.flush",   32'(bus_a.flush),   32'd0);
        check_val("run.running", 32'(bus_a.running), 32'd1);

        // Redirect together with a held stall; wrong-path brReq in DRAIN.
        bus_a.hazardStall = 1'b1;
        bus_a.brReq = 1'b1;
        bus_a.brReqOffset = 24'h000020;
        tick();
        bus_a.brReq = 1'b0;
        #1;
        check_val("sredir.brTaken",  32'(bus_a.brTaken),  32'd1);
        check_val("sredir.freeze",   32'(bus_a.freeze),   32'd0);
        check_val("sredir.brOffset", 32'(bus_a.brOffset), 32'h20);
        tick();
        check_val("sdrain.flush",  32'(bus_a.flush),  32'd1);
        check_val("sdrain.freeze", 32'(bus_a.freeze), 32'd1);
        bus_a.brReq = 1'b1;
        bus_a.brReqOffset = 24'h000055;
        tick();
        bus_a.brReq = 1'b0;
        #1;
        check_val("sdrain_hold.flush",   32'(bus_a.flush),         32'd1);
        check_val("sdrain_br.brTaken",   32'(bus_a.brTaken),       32'd0);
        check_val("sdrain_br.count",     32'(bus_a.redirectCount), 32'd2);
        tick();
        check_val("sdrain_hold2.flush", 32'(bus_a.flush), 32'd1);
        bus_a.hazardStall = 1'b0;
        #1;
        check_val("sdrain_go.freeze", 32'(bus_a.freeze), 32'd0);
        tick();
        check_val("sdrain_c1.flush", 32'(bus_a.flush), 32'd1);
        tick();
        check_val("sdrain_run.flush",   32'(bus_a.flush),   32'd0);
        check_val("sdrain_run.running", 32'(bus_a.running), 32'd1);

        // Halt opcode under stall is ignored.
        bus_a.instruction = 16'hF000;
        bus_a.hazardStall = 1'b1;
        tick();
        check_val("halt_stall.halted",  32'(bus_a.halted),  32'd0);
        check_val("halt_stall.running", 32'(bus_a.running), 32'd1);

        // Halt opcode with brReq redirects; halt stays suppressed through drain.
        bus_a.hazardStall = 1'b0;
        bus_a.brReq = 1'b1;
        bus_a.brReqOffset = 24'h000008;
        tick();
        bus_a.brReq = 1'b0;
        #1;
        check_val("halt_br.brTaken", 32'(bus_a.brTaken),       32'd1);
        check_val("halt_br.halted",  32'(bus_a.halted),        32'd0);
        check_val("halt_br.count",   32'(bus_a.redirectCount), 32'd3);
        tick();
        check_val("halt_drain1.halted", 32'(bus_a.halted), 32'd0);
        tick();
        check_val("halt_drain2.halted", 32'(bus_a.halted), 32'd0);
        tick();
        check_val("halt_run.running", 32'(bus_a.running), 32'd1);
        check_val("halt_run.halted",  32'(bus_a.halted),  32'd0);

        // Halt opcode in unstalled RUN halts.
        tick();
        check_val("halt.halted",  32'(bus_a.halted),  32'd1);
        check_val("halt.freeze",  32'(bus_a.freeze),  32'd1);
        check_val("halt.running", 32'(bus_a.running), 32'd0);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        #1;
        check_val("halt_start.halted",  32'(bus_a.halted),  32'd1);
        check_val("halt_start.running", 32'(bus_a.running), 32'd0);

        // Leave HALT through reset, restart, then reset mid-DRAIN.
        rst = 1'b1;
        bus_a.instruction = 16'h0000;
        tick();
        rst = 1'b0;
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        #1;
        check_val("restart.running", 32'(bus_a.running),       32'd1);
        check_val("restart.count",   32'(bus_a.redirectCount), 32'd0);
        bus_a.brReq = 1'b1;
        bus_a.brReqOffset = 24'h000030;
        tick();
        bus_a.brReq = 1'b0;
        #1;
        check_val("mid.brOffset", 32'(bus_a.brOffset), 32'h30);
        tick();
        check_val("mid_drain.flush", 32'(bus_a.flush), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check_reset_a("rst_drain");

        // FLUSH_CYCLES = 0 build: REDIRECT goes straight back to RUN.
        bus_z.start = 1'b1;
        tick();
        bus_z.start = 1'b0;
        #1;
        check_val("z_start.running", 32'(bus_z.running), 32'd1);
        bus_z.brReq = 1'b1;
        bus_z.brReqOffset = 24'h000040;
        tick();
        bus_z.brReq = 1'b0;
        #1;
        check_val("z_redir.brTaken",  32'(bus_z.brTaken),  32'd1);
        check_val("z_redir.flush",    32'(bus_z.flush),    32'd1);
        check_val("z_redir.brOffset", 32'(bus_z.brOffset), 32'h40);
        tick();
        check_val("z_run.flush",   32'(bus_z.flush),         32'd0);
        check_val("z_run.brTaken", 32'(bus_z.brTaken),       32'd0);
        check_val("z_run.running", 32'(bus_z.running),       32'd1);
        check_val("z_run.count",   32'(bus_z.redirectCount), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
